instr_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the pipelined MIPS core. It accepts a framed byte stream from the serial receiver, assembles 32-bit instruction words, and writes them into instruction memory at word addresses 0..N-1. It holds the core in reset until a complete, checksum-verified image is stored, then releases it so fetch starts at PC 0.

---
 rtl/instr_loader_pkg.sv | 22 ++
 rtl/instr_loader_word_packer.sv | 51 +++++
 rtl/instr_loader.sv | 175 +++++++++++++++++
 tb/tb_instr_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states, sizing
// constants and the frame-header range check.
package instr_loader_pkg;

  localparam int ADDR_W_DEFAULT  = 5;
  localparam int MAX_WORDS       = 1 << ADDR_W_DEFAULT;
  localparam int TIMEOUT_DEFAULT = 1_000_000;

  typedef enum logic [2:0] {
    WAIT_HDR,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  // A header is usable only if it asks for between 1 and max_words words.
  function automatic logic header_ok(input logic [7:0] n, input int max_words);
    return (n != 8'd0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Assembles MSB-first bytes into 32-bit words and keeps the running XOR of
// every byte accepted since the last clear.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_strobe,
  output logic [7:0]  xor_out
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    xor_d   = xor_q;
    if (clear) begin
      idx_d   = '0;
      shift_d = '0;
      xor_d   = '0;
    end else if (strobe) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
      xor_d   = xor_q ^ byte_in;
    end
  end

  // The word is presented while its fourth byte is still on the bus, so the
  // three earlier bytes only need 24 bits of storage.
  assign word        = {shift_q, byte_in};
  assign word_strobe = strobe && !clear && (idx_q == 2'd3);
  assign xor_out     = xor_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      shift_q <= '0;
      xor_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a framed, checksummed image over a byte stream, writes
// it to instruction memory and releases the core once the image verifies.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              core_reset,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MAX_W = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  loader_state_t state_q, state_d;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              core_reset_q, core_reset_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic        xfer;
  logic        hdr_valid;
  logic        timed_out;
  logic        pk_strobe;
  logic        pk_clear;
  logic        word_strobe;
  logic [31:0] word;
  logic [7:0]  xor_val;

  assign rx_ready  = (state_q != RUN) || !reset;
  assign xfer      = rx_valid && rx_ready;
  assign hdr_valid = header_ok(rx_data, MAX_W);
  assign timed_out = (tmo_q == TMO_W'(TIMEOUT));

  // Clearing while waiting for a header also drops any partial word left by a timeout.
  assign pk_clear  = (state_q == WAIT_HDR) || (state_q == ERROR);
  assign pk_strobe = xfer && (state_q == LOAD) && !timed_out;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (rx_data),
    .strobe     (pk_strobe),
    .clear      (pk_clear),
    .word       (word),
    .word_strobe(word_strobe),
    .xor_out    (xor_val)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    tmo_d    = tmo_q;

    case (state_q)
      WAIT_HDR, ERROR: begin
        tmo_d = '0;
        if (xfer) begin
          if (hdr_valid) begin
            state_d  = LOAD;
            target_d = rx_data[CNT_W-1:0];
            count_d  = '0;
          end else begin
            state_d = ERROR;
          end
        end
      end

      LOAD: begin
        if (timed_out) begin
          state_d = ERROR;
        end else if (xfer) begin
          tmo_d = '0;
          if (word_strobe) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = word;
            count_d = count_q + 1'b1;
            if (count_q + 1'b1 == target_q) begin
              state_d = CHECK;
            end
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CHECK: begin
        if (timed_out) begin
          state_d = ERROR;
        end else if (xfer) begin
          tmo_d   = '0;
          state_d = (rx_data == xor_val) ? RUN : ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RUN: begin
        state_d = RUN;
      end

      default: begin
        state_d = WAIT_HDR;
      end
    endcase

    core_reset_d = (state_d != RUN);
    loading_d    = (state_d == LOAD) || (state_d == CHECK);
    done_d       = (state_d == RUN);
    error_d      = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_HDR;
      count_q      <= '0;
      target_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      tmo_q        <= '0;
      core_reset_q <= 1'b1;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      target_q     <= target_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      tmo_q        <= tmo_d;
      core_reset_q <= core_reset_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign imem_we      = we_q;
  assign core_reset   = core_reset_q;
  assign loading      = loading_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: good/bad frames, header limits, timeout,
// mid-frame reset and the RUN lock-out.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        core_reset;
  logic        loading;
  logic        done;
  logic        error;
  logic [5:0]  words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  logic [7:0] frame_a [10] = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h24};

  instr_loader #(.ADDR_W(5), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .imem_we     (imem_we),
    .core_reset  (core_reset),
    .loading     (loading),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe so later steps can audit what reached memory.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"},     32'(rx_ready),     32'd1);
    checkOutput({tag, "_imem_we"},      32'(imem_we),      32'd0);
    checkOutput({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
    checkOutput({tag, "_imem_wdata"},   imem_wdata,        32'd0);
    checkOutput({tag, "_core_reset"},   32'(core_reset),   32'd1);
    checkOutput({tag, "_loading"},      32'(loading),      32'd0);
    checkOutput({tag, "_done"},         32'(done),         32'd0);
    checkOutput({tag, "_error"},        32'(error),        32'd0);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int base;
    int cyc;

    // Power-on reset, checked while still asserted
    #1 reset = 1'b0;
    #2 checkResetValues("por");
    @(negedge clk);
    reset = 1'b1;

    // Good two-word frame with cycle-exact write strobes
    for (int i = 0; i < 10; i++) begin
      applyStimulus(frame_a[i]);
      if (i == 0) checkOutput("f1_loading_hdr", 32'(loading), 32'd1);
      if (i == 4) begin
        checkOutput("f1_w0_we",    32'(imem_we),      32'd1);
        checkOutput("f1_w0_addr",  32'(imem_addr),    32'd0);
        checkOutput("f1_w0_data",  imem_wdata,        32'h20010005);
        checkOutput("f1_w0_count", 32'(words_loaded), 32'd1);
      end
      if (i == 5) checkOutput("f1_we_one_cycle", 32'(imem_we), 32'd0);
      if (i == 8) begin
        checkOutput("f1_w1_we",    32'(imem_we),      32'd1);
        checkOutput("f1_w1_addr",  32'(imem_addr),    32'd1);
        checkOutput("f1_w1_data",  imem_wdata,        32'h00000000);
        checkOutput("f1_w1_count", 32'(words_loaded), 32'd2);
        checkOutput("f1_core_reset_held", 32'(core_reset), 32'd1);
      end
    end
    checkOutput("f1_done",       32'(done),         32'd1);
    checkOutput("f1_core_reset", 32'(core_reset),   32'd0);
    checkOutput("f1_error",      32'(error),        32'd0);
    checkOutput("f1_rx_ready",   32'(rx_ready),     32'd0);
    checkOutput("f1_loading",    32'(loading),      32'd0);
    checkOutput("f1_we_after",   32'(imem_we),      32'd0);
    checkOutput("f1_words",      32'(words_loaded), 32'd2);
    checkOutput("f1_writes",     32'(wr_addr.size()), 32'd2);

    // RUN ignores a held-valid byte stream
    @(negedge clk);
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("run_rx_ready", 32'(rx_ready),        32'd0);
    checkOutput("run_done",     32'(done),            32'd1);
    checkOutput("run_writes",   32'(wr_addr.size()),  32'd2);
    checkOutput("run_words",    32'(words_loaded),    32'd2);
    rx_valid = 1'b0;

    // Bad checksum, then a correct frame recovers
    pulseReset();
    base = wr_addr.size();
    for (int i = 0; i < 9; i++) applyStimulus(frame_a[i]);
    applyStimulus(8'h25);
    checkOutput("badck_error",      32'(error),      32'd1);
    checkOutput("badck_core_reset", 32'(core_reset), 32'd1);
    checkOutput("badck_done",       32'(done),       32'd0);
    checkOutput("badck_loading",    32'(loading),    32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(frame_a[i]);
      if (i == 0) checkOutput("recov_error_cleared", 32'(error), 32'd0);
    end
    checkOutput("recov_done",   32'(done),                   32'd1);
    checkOutput("recov_writes", 32'(wr_addr.size() - base),  32'd4);

    // Header limits and a full 32-word image
    pulseReset();
    base = wr_addr.size();
    applyStimulus(8'h00);
    checkOutput("hdr00_error", 32'(error), 32'd1);
    applyStimulus(8'h21);
    checkOutput("hdr21_error",   32'(error),   32'd1);
    checkOutput("hdr21_loading", 32'(loading), 32'd0);
    checkOutput("hdr_bad_no_writes", 32'(wr_addr.size() - base), 32'd0);
    applyStimulus(8'h20);
    checkOutput("hdr20_error",   32'(error),   32'd0);
    checkOutput("hdr20_loading", 32'(loading), 32'd1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(8'hA0);
      applyStimulus(8'(i));
      applyStimulus(8'h00);
      applyStimulus(8'h0F);
    end
    applyStimulus(8'h00);
    checkOutput("full_done",   32'(done),         32'd1);
    checkOutput("full_words",  32'(words_loaded), 32'd32);
    checkOutput("full_writes", 32'(wr_addr.size() - base), 32'd32);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("full_addr_%0d", i), 32'(wr_addr[base + i]), 32'(i));
      checkOutput($sformatf("full_data_%0d", i), wr_data[base + i],
                  {8'hA0, 8'(i), 8'h00, 8'h0F});
    end

    // Idle timeout mid-word, then a clean frame
    pulseReset();
    base = wr_addr.size();
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("tmo_not_yet",     32'(error),   32'd0);
    checkOutput("tmo_loading_yet", 32'(loading), 32'd1);
    cyc = 0;
    while (!error && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("tmo_error",      32'(error),      32'd1);
    checkOutput("tmo_core_reset", 32'(core_reset), 32'd1);
    checkOutput("tmo_no_writes",  32'(wr_addr.size() - base), 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    applyStimulus(8'h22);
    checkOutput("tmo_recov_done",   32'(done),                  32'd1);
    checkOutput("tmo_recov_writes", 32'(wr_addr.size() - base), 32'd1);
    checkOutput("tmo_recov_addr",   32'(wr_addr[base]),         32'd0);
    checkOutput("tmo_recov_data",   wr_data[base],              32'hDEADBEEF);

    // Asynchronous reset in the middle of a three-word frame
    pulseReset();
    applyStimulus(8'h03);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    applyStimulus(8'h05);
    checkOutput("mid_words_before", 32'(words_loaded), 32'd1);
    checkOutput("mid_data_before",  imem_wdata,        32'h01020304);
    #2 reset = 1'b0;
    #1 checkResetValues("mid");
    @(negedge clk);
    reset = 1'b1;
    base = wr_addr.size();
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    applyStimulus(8'h08);
    checkOutput("mid_recov_done",       32'(done),                  32'd1);
    checkOutput("mid_recov_core_reset", 32'(core_reset),            32'd0);
    checkOutput("mid_recov_writes",     32'(wr_addr.size() - base), 32'd1);
    checkOutput("mid_recov_addr",       32'(wr_addr[base]),         32'd0);
    checkOutput("mid_recov_data",       wr_data[base],              32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
